i2s_rx_bram_writer: RTL and testbench
=====================================

// Module: i2s_rx_bram_writer
// PURPOSE
//  Record path, the mirror of the playback DMA. Deserialises an I2S capture stream
//  (codec ADC -> PL), packs one stereo frame per 32-bit word {R[15:0],L[15:0]} and
//  writes it into a BRAM ring for the PS to read. Single clock domain clk: the I2S
//  bclk/lrc/data pins are oversampled as plain inputs.
//  One-shot or continuous capture is started and stopped by PS control bits.
// PARAMETERS
//  SAMPLE_BITS  16   bits captured per channel, MSB first; later slot bits ignored
//  CLIP_LEN     64   words in the BRAM ring (power of two, >=2)
//  ADDR_INCR    1    BRAM_addr step per word (1 = word addressing)
//  BASE_ADDR    0    BRAM_addr of word 0
// PORTS
//  clk              in   1   system clock; also drives BRAM_clk; must be >= 4x bclk
//  rst              in   1   asynchronous, active-low reset
//  start            in   1   1-cycle pulse: clear index/flags and arm capture
//  stop             in   1   1-cycle pulse: abort to IDLE
//  continuous       in   1   1 = wrap ring forever; 0 = stop after CLIP_LEN words
//  audio_I2S_bclk   in   1   codec bit clock
//  audio_I2S_reclrc in   1   word select: 0 = left slot, 1 = right slot
//  audio_I2S_recdat in   1   serial capture data
//  BRAM_addr        out  32  write address
//  BRAM_clk         out  1   = clk
//  BRAM_din         out  32  {right, left} (each zero-extended to 16 b if SAMPLE_BITS<16)
//  BRAM_dout        in   32  unused (port compatibility)
//  BRAM_en          out  1   port enable, high only in the WRITE cycle
//  BRAM_rst         out  1   BRAM reset
//  BRAM_we          out  4   byte write enables; 4'hF in WRITE, else 0
//  wr_index         out  $clog2(CLIP_LEN)  index of the next word to write
//  busy             out  1   state is SYNC, CAPTURE or WRITE
//  done             out  1   one-shot finished; held until start or stop
//  overrun          out  1   sticky: frame completed while a write was pending
// BEHAVIOUR
//  Reset (rst=0): state IDLE; BRAM_addr=BASE_ADDR; BRAM_din=0; BRAM_en=0; BRAM_we=0;
//   BRAM_rst=1 (released on the first clk after deassertion); wr_index=0; done=0;
//   overrun=0; synchronisers 0. An asserted reset mid-write drops the write.
//  Input path: 2-flop synchroniser on bclk, lrc and dat. bclk_rise = sync 0->1.
//   All slot logic advances only on bclk_rise, using the synced lrc/dat.
//  Slot framing (standard I2S, 1-bit delay): at the bclk_rise where lrc differs from
//   its value at the previous rise, the bit is the previous slot's LSB -> discard;
//   bit_cnt <= 0. The next SAMPLE_BITS rises shift dat in MSB first.
//   At bit_cnt==SAMPLE_BITS the slot is complete: lrc=0 -> latch left, lrc=1 -> latch
//   right and raise frame_rdy for one clk.
//  FSM:
//   IDLE    en=0; start -> SYNC (wr_index=0, done=0, overrun=0).
//   SYNC    discard bits until the first lrc 1->0 change (left slot start) -> CAPTURE.
//   CAPTURE frame_rdy -> WRITE, BRAM_din={right,left}. A right slot not preceded
//           by a complete left slot in the same frame is dropped (no write).
//   WRITE   exactly 1 clk: BRAM_en=1, BRAM_we=4'hF, BRAM_addr=BASE_ADDR+wr_index*ADDR_INCR.
//           Next: wr_index+1 (wraps CLIP_LEN-1 -> 0). If !continuous and the
//           written index was CLIP_LEN-1 -> DONE, else -> CAPTURE.
//   DONE    done=1, en=0; start -> SYNC; stop -> IDLE.
//  Latency: BRAM write asserted on the 1st clk after frame_rdy; frame_rdy is 3 clk
//   (synchroniser + edge detect) after the bclk edge sampling the right LSB.
//  Overrun: frame_rdy while in WRITE -> overrun=1; that frame is dropped.
//  stop: from any state -> IDLE next clk; a write on the bus that cycle completes;
//   done cleared. start and stop in the same cycle: stop wins.
//  start while busy: restart at SYNC with wr_index=0.
//  continuous toggled mid-capture: sampled at each WRITE.
//  lrc glitch mid-slot: bit_cnt restarts; the partial slot is never written.
// TESTING
//  1 one-shot, CLIP_LEN=64, frames L=16'h1000+n, R=16'h2000+n -> 64 writes, addr 0..63,
//    din[n]={16'h2000+n,16'h1000+n}; done=1; no further writes.
//  2 continuous, 70 frames -> word 0 overwritten by frame 64 and word 5 by frame 69;
//    wr_index=6; done stays 0.
//  3 start mid right slot -> first write is the next complete L/R frame; no partial word.
//  4 stop 2 clk after frame 10's WRITE -> IDLE, busy=0, BRAM_en=0; no write for frame 11.
//  5 rst low during WRITE -> BRAM_en/we=0 immediately; after release: BRAM_rst=1 for
//    1 clk, wr_index=0.
//  6 bclk = clk/4 with frame_rdy forced during WRITE -> overrun=1; frame dropped;
//    start clears overrun.

Source files
------------

// File: rtl/i2s_rx_bram_writer.sv
`timescale 1ns/1ps
// I2S capture receiver: oversamples bclk/lrc/dat on clk, deserialises left/right
// slots and writes packed {R,L} frames into a BRAM ring under PS start/stop control.
module i2s_rx_bram_writer #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned CLIP_LEN    = 64,
    parameter int unsigned ADDR_INCR   = 1,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        continuous,
    input  logic                        audio_I2S_bclk,
    input  logic                        audio_I2S_reclrc,
    input  logic                        audio_I2S_recdat,
    output logic [31:0]                 BRAM_addr,
    output logic                        BRAM_clk,
    output logic [31:0]                 BRAM_din,
    input  logic [31:0]                 BRAM_dout,
    output logic                        BRAM_en,
    output logic                        BRAM_rst,
    output logic [3:0]                  BRAM_we,
    output logic [$clog2(CLIP_LEN)-1:0] wr_index,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);
    localparam int unsigned IW = $clog2(CLIP_LEN);
    localparam int unsigned BW = $clog2(SAMPLE_BITS + 1);
    localparam logic [BW-1:0] BITS_FULL = BW'(SAMPLE_BITS);
    localparam logic [BW-1:0] BITS_LAST = BW'(SAMPLE_BITS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(CLIP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic logic [15:0] ext16(input logic [SAMPLE_BITS-1:0] v);
        ext16 = 16'(v);
    endfunction

    logic bclk_s1_q, bclk_s2_q, bclk_d1_q;
    logic lrc_s1_q, lrc_s2_q, dat_s1_q, dat_s2_q;
    logic                   lrc_prev_q, lrc_prev_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [15:0]            left_q, left_d;
    logic                   left_ok_q, left_ok_d;
    logic [31:0]            frame_q, frame_d;
    logic                   frame_rdy_q, frame_rdy_d;
    logic                   frame_rdy_s;
    logic                   bclk_rise_s, lrc_chg_s, lrc_fall_s;
    logic [SAMPLE_BITS-1:0] shifted_s;

    state_t        state_q, state_d;
    logic [IW-1:0] wr_index_q, wr_index_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;
    logic          en_q, en_d;
    logic [3:0]    we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   din_q, din_d;
    logic          bram_rst_q;
    logic          unused_dout_s;

    assign frame_rdy_s   = frame_rdy_q;
    assign unused_dout_s = ^BRAM_dout;

    // Slot framing: the rise where lrc changes carries the previous slot's LSB.
    always_comb begin
        bclk_rise_s = bclk_s2_q & ~bclk_d1_q;
        lrc_chg_s   = lrc_s2_q ^ lrc_prev_q;
        lrc_fall_s  = bclk_rise_s & lrc_chg_s & ~lrc_s2_q;
        shifted_s   = (shift_q << 1'b1) | SAMPLE_BITS'(dat_s2_q);
        lrc_prev_d  = lrc_prev_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_d      = left_q;
        left_ok_d   = left_ok_q;
        frame_d     = frame_q;
        frame_rdy_d = 1'b0;
        if (bclk_rise_s) begin
            lrc_prev_d = lrc_s2_q;
            if (lrc_chg_s) begin
                bit_cnt_d = '0;
                if (!lrc_s2_q) begin
                    left_ok_d = 1'b0;
                end else begin
                    left_ok_d = left_ok_q;
                end
            end else if (bit_cnt_q < BITS_FULL) begin
                shift_d   = shifted_s;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BITS_LAST) begin
                    if (!lrc_s2_q) begin
                        left_d    = ext16(shifted_s);
                        left_ok_d = 1'b1;
                    end else if (left_ok_q) begin
                        frame_d     = {ext16(shifted_s), left_q};
                        frame_rdy_d = 1'b1;
                        left_ok_d   = 1'b0;
                    end else begin
                        left_ok_d = 1'b0;
                    end
                end else begin
                    left_ok_d = left_ok_q;
                end
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            lrc_prev_d = lrc_prev_q;
        end
    end

    // Input synchronisers and slot deserialiser state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_d1_q   <= 1'b0;
            lrc_s1_q    <= 1'b0;
            lrc_s2_q    <= 1'b0;
            dat_s1_q    <= 1'b0;
            dat_s2_q    <= 1'b0;
            lrc_prev_q  <= 1'b0;
            bit_cnt_q   <= BITS_FULL;
            shift_q     <= '0;
            left_q      <= 16'h0000;
            left_ok_q   <= 1'b0;
            frame_q     <= 32'h0000_0000;
            frame_rdy_q <= 1'b0;
        end else begin
            bclk_s1_q   <= audio_I2S_bclk;
            bclk_s2_q   <= bclk_s1_q;
            bclk_d1_q   <= bclk_s2_q;
            lrc_s1_q    <= audio_I2S_reclrc;
            lrc_s2_q    <= lrc_s1_q;
            dat_s1_q    <= audio_I2S_recdat;
            dat_s2_q    <= dat_s1_q;
            lrc_prev_q  <= lrc_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            left_ok_q   <= left_ok_d;
            frame_q     <= frame_d;
            frame_rdy_q <= frame_rdy_d;
        end
    end

    // Capture FSM next-state; stop beats start, and bus outputs are registered.
    always_comb begin
        state_d    = state_q;
        wr_index_d = wr_index_q;
        done_d     = done_q;
        overrun_d  = overrun_q;
        en_d       = 1'b0;
        we_d       = 4'h0;
        addr_d     = addr_q;
        din_d      = din_q;
        if (stop) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else if (start) begin
            state_d    = S_SYNC;
            wr_index_d = '0;
            done_d     = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_SYNC: begin
                    if (lrc_fall_s) begin
                        state_d = S_CAPTURE;
                    end else begin
                        state_d = S_SYNC;
                    end
                end
                S_CAPTURE: begin
                    if (frame_rdy_s) begin
                        state_d = S_WRITE;
                        en_d    = 1'b1;
                        we_d    = 4'hF;
                        addr_d  = 32'(BASE_ADDR) + 32'(wr_index_q) * 32'(ADDR_INCR);
                        din_d   = frame_q;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
                S_WRITE: begin
                    wr_index_d = wr_index_q + 1'b1;
                    if (frame_rdy_s) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                    if (!continuous && (wr_index_q == IDX_LAST)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_SYNC) || (state_d == S_CAPTURE) || (state_d == S_WRITE);
    end

    // FSM state and registered BRAM/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_index_q <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 4'h0;
            addr_q     <= 32'(BASE_ADDR);
            din_q      <= 32'h0000_0000;
            bram_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_index_q <= wr_index_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            bram_rst_q <= 1'b0;
        end
    end

    assign BRAM_clk  = clk;
    assign BRAM_addr = addr_q;
    assign BRAM_din  = din_q;
    assign BRAM_en   = en_q;
    assign BRAM_we   = we_q;
    assign BRAM_rst  = bram_rst_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_rx_bram_writer.sv
`timescale 1ns/1ps
// Directed bench for i2s_rx_bram_writer: drives an I2S stream at clk/4 with 17-bclk
// slots and checks the logged BRAM writes and status flags against hand-built values.
module tb_i2s_rx_bram_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic        bclk = 1'b0;
    logic        lrc = 1'b1;
    logic        dat = 1'b0;
    logic [31:0] bram_addr;
    logic        bram_clk;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = 32'h0000_0000;
    logic        bram_en;
    logic        bram_rst;
    logic [3:0]  bram_we;
    logic [5:0]  wr_index;
    logic        busy;
    logic        done;
    logic        overrun;

    int total = 0;
    int bad = 0;
    int base = 0;
    logic [31:0] log_addr [$];
    logic [31:0] log_din [$];
    logic [3:0]  log_we [$];

    i2s_rx_bram_writer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .audio_I2S_bclk(bclk), .audio_I2S_reclrc(lrc), .audio_I2S_recdat(dat),
        .BRAM_addr(bram_addr), .BRAM_clk(bram_clk), .BRAM_din(bram_din),
        .BRAM_dout(bram_dout), .BRAM_en(bram_en), .BRAM_rst(bram_rst), .BRAM_we(bram_we),
        .wr_index(wr_index), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && bram_en) begin
            log_addr.push_back(bram_addr);
            log_din.push_back(bram_din);
            log_we.push_back(bram_we);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_at(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] din_at(input int i);
        return (i < log_din.size()) ? log_din[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] we_at(input int i);
        return (i < log_we.size()) ? 32'(log_we[i]) : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] word(input logic [15:0] l0, input logic [15:0] r0, input int n);
        return {r0 + 16'(n), l0 + 16'(n)};
    endfunction

    task automatic bclk_cycle(input logic l, input logic d, input logic pulse);
        lrc = l;
        dat = d;
        start = pulse;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 bclk = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 bclk = 1'b0;
    endtask

    // Slot = 1 pad bit under the new lrc, then 16 data bits MSB first.
    task automatic send_slot(input logic l, input logic [15:0] s, input int start_at);
        bclk_cycle(l, 1'b1, start_at == 0);
        for (int i = 15; i >= 0; i--) bclk_cycle(l, s[i], start_at == (16 - i));
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, -1);
        send_slot(1'b1, r, -1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_en(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bram_en !== 1'b1 && k < 40);
        chk(tag, 32'(bram_en), 32'd1);
    endtask

    initial begin
        // Reset state
        #22;
        chk("rst_en", 32'(bram_en), 32'd0);
        chk("rst_we", 32'(bram_we), 32'd0);
        chk("rst_addr", bram_addr, 32'd0);
        chk("rst_din", bram_din, 32'd0);
        chk("rst_bram_rst", 32'(bram_rst), 32'd1);
        chk("rst_wr_index", 32'(wr_index), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rel_bram_rst_hold", 32'(bram_rst), 32'd1);
        @(posedge clk); #1;
        chk("rel_bram_rst_drop", 32'(bram_rst), 32'd0);
        send_slot(1'b1, 16'h0000, -1);

        // 1: one-shot, 64 frames
        continuous = 1'b0;
        pulse_start();
        idle(1);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int n = 0; n < 64; n++) send_frame(16'h1000 + 16'(n), 16'h2000 + 16'(n));
        idle(8);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_wr_index", 32'(wr_index), 32'd0);
        send_frame(16'hBEEF, 16'hCAFE);
        send_frame(16'hBEEF, 16'hCAFE);
        idle(8);
        chk("t1_count", 32'(log_din.size()), 32'd64);
        chk("t1_done_hold", 32'(done), 32'd1);
        for (int n = 0; n < 64; n++) begin
            chk("t1_addr", addr_at(n), 32'(n));
            chk("t1_din", din_at(n), word(16'h1000, 16'h2000, n));
            chk("t1_we", we_at(n), 32'h0000_000F);
        end

        // 2: continuous, 70 frames wrap the ring
        continuous = 1'b1;
        base = log_din.size();
        pulse_start();
        idle(1);
        chk("t2_done_clr", 32'(done), 32'd0);
        for (int n = 0; n < 70; n++) send_frame(16'h1000 + 16'(n), 16'h2000 + 16'(n));
        idle(8);
        chk("t2_count", 32'(log_din.size() - base), 32'd70);
        for (int n = 0; n < 70; n++) begin
            chk("t2_addr", addr_at(base + n), 32'(n % 64));
            chk("t2_din", din_at(base + n), word(16'h1000, 16'h2000, n));
        end
        chk("t2_wr_index", 32'(wr_index), 32'd6);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);

        // 3: start in the middle of a right slot
        base = log_din.size();
        send_slot(1'b0, 16'hAAAA, -1);
        send_slot(1'b1, 16'h5555, 8);
        send_frame(16'h1234, 16'h5678);
        idle(8);
        chk("t3_count", 32'(log_din.size() - base), 32'd1);
        chk("t3_addr", addr_at(base), 32'd0);
        chk("t3_din", din_at(base), 32'h5678_1234);
        chk("t3_wr_index", 32'(wr_index), 32'd1);

        // 4: stop two clocks after frame 10's write
        base = log_din.size();
        pulse_start();
        for (int n = 0; n < 10; n++) send_frame(16'h3000 + 16'(n), 16'h4000 + 16'(n));
        send_frame(16'h300A, 16'h400A);
        wait_en("t4_wait_write10");
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_stop();
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_en", 32'(bram_en), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        send_frame(16'h300B, 16'h400B);
        idle(8);
        chk("t4_count", 32'(log_din.size() - base), 32'd11);
        chk("t4_last_addr", addr_at(base + 10), 32'd10);
        chk("t4_last_din", din_at(base + 10), 32'h400A_300A);

        // 5: reset asserted during a write
        pulse_start();
        send_frame(16'h5555, 16'h6666);
        wait_en("t5_wait_write");
        #1 rst = 1'b0;
        #1;
        chk("t5_en_drop", 32'(bram_en), 32'd0);
        chk("t5_we_drop", 32'(bram_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("t5_bram_rst_hold", 32'(bram_rst), 32'd1);
        @(posedge clk); #1;
        chk("t5_bram_rst_drop", 32'(bram_rst), 32'd0);
        chk("t5_wr_index", 32'(wr_index), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);

        // 6: frame_rdy during WRITE sets overrun and drops that frame
        send_slot(1'b1, 16'h0000, -1);
        pulse_start();
        base = log_din.size();
        send_frame(16'h7001, 16'h8001);
        wait_en("t6_wait_write");
        chk("t6_first_addr", bram_addr, 32'd0);
        force dut.frame_rdy_s = 1'b1;
        @(posedge clk); #1;
        release dut.frame_rdy_s;
        chk("t6_overrun", 32'(overrun), 32'd1);
        chk("t6_no_write", 32'(bram_en), 32'd0);
        chk("t6_wr_index", 32'(wr_index), 32'd1);
        idle(4);
        chk("t6_dropped", 32'(log_din.size() - base), 32'd1);
        send_frame(16'h7002, 16'h8002);
        idle(8);
        chk("t6_next_addr", addr_at(base + 1), 32'd1);
        chk("t6_next_din", din_at(base + 1), 32'h8002_7002);
        chk("t6_sticky", 32'(overrun), 32'd1);
        pulse_start();
        chk("t6_start_clears", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
